// File: rtl/ibex_fetch_aligner.sv
// Fetch-word queue that realigns 32-bit memory words into 16/32-bit instructions,
// presenting one instruction at a time with its PC and a first-cycle qualifier.
module ibex_fetch_aligner #(
   parameter int unsigned DEPTH = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic [31:0] clear_addr_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_rdata_i,
   input  logic        in_err_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_rdata_o,
   output logic [31:0] out_addr_o,
   output logic        out_err_o,
   output logic        out_is_compressed_o,
   output logic        instr_new_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [CW-1:0]   count_q, count_d;
   logic            off_q, off_d;
   logic [31:0]     pc_q, pc_d;
   logic            presented_q, presented_d;

   entry_t          head, nxt;
   logic [15:0]     half;
   logic            is_cmp;
   logic            has1, has2, err_only;
   logic            pop, push, pop_word;
   logic [CW-1:0]   wr_idx;

   assign head   = mem_q[0];
   assign nxt    = mem_q[1];
   assign half   = off_q ? head.data[31:16] : head.data[15:0];
   assign is_cmp = (half[1:0] != 2'b11);
   assign has1   = (count_q != '0);
   assign has2   = (count_q >= CW'(2));
   // upper half of a misaligned 32-bit instruction will never arrive: present the error now
   assign err_only = off_q & ~is_cmp & (count_q == CW'(1)) & head.err;

   assign in_ready_o = (count_q < CW'(DEPTH));

   // Output mux
   always_comb begin
      out_valid_o = 1'b0;
      out_rdata_o = '0;
      out_err_o   = head.err;
      if (is_cmp || !off_q) begin
         out_valid_o = has1;
      end else begin
         out_valid_o = has2 | err_only;
      end
      if (is_cmp || err_only) begin
         out_rdata_o = {16'h0000, half};
      end else if (!off_q) begin
         out_rdata_o = head.data;
      end else begin
         out_rdata_o = {nxt.data[15:0], head.data[31:16]};
         out_err_o   = head.err | nxt.err;
      end
      out_is_compressed_o = out_valid_o & is_cmp;
      instr_new_o         = out_valid_o & ~presented_q;
   end

   assign out_addr_o = pc_q;
   assign pop        = out_valid_o & out_ready_i;
   assign push       = in_valid_i & in_ready_o;
   assign pop_word   = pop & (off_q | ~is_cmp);
   assign wr_idx     = count_q - CW'(pop_word);

   // Next-state
   always_comb begin
      mem_d       = mem_q;
      count_d     = count_q;
      off_d       = off_q;
      pc_d        = pc_q;
      presented_d = presented_q;
      if (clear_i) begin
         count_d     = '0;
         off_d       = clear_addr_i[1];
         pc_d        = {clear_addr_i[31:1], 1'b0};
         presented_d = 1'b0;
      end else begin
         if (pop_word) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
               mem_d[i] = mem_q[i+1];
            end
         end
         if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (CW'(i) == wr_idx) begin
                  mem_d[i] = {in_err_i, in_rdata_i};
               end
            end
         end
         count_d = count_q + CW'(push) - CW'(pop_word);
         if (pop) begin
            pc_d        = pc_q + (is_cmp ? 32'd2 : 32'd4);
            presented_d = 1'b0;
            if (is_cmp) begin
               off_d = ~off_q;
            end
         end else if (out_valid_o) begin
            presented_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         count_q     <= '0;
         off_q       <= 1'b0;
         pc_q        <= '0;
         presented_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         count_q     <= count_d;
         off_q       <= off_d;
         pc_q        <= pc_d;
         presented_q <= presented_d;
      end
   end

endmodule

// File: tb/tb_ibex_fetch_aligner.sv
// Bench for ibex_fetch_aligner: directed plan steps, then random traffic against
// a halfword-queue reference model.
module tb_ibex_fetch_aligner;

   localparam int unsigned DEPTH = 3;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic [31:0] clear_addr_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_rdata_i;
   logic        in_err_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_rdata_o;
   logic [31:0] out_addr_o;
   logic        out_err_o;
   logic        out_is_compressed_o;
   logic        instr_new_o;

   ibex_fetch_aligner #(.DEPTH(DEPTH)) dut (
      .clk_i               (clk),
      .rst_ni              (rst_ni),
      .clear_i             (clear_i),
      .clear_addr_i        (clear_addr_i),
      .in_valid_i          (in_valid_i),
      .in_ready_o          (in_ready_o),
      .in_rdata_i          (in_rdata_i),
      .in_err_i            (in_err_i),
      .out_valid_o         (out_valid_o),
      .out_ready_i         (out_ready_i),
      .out_rdata_o         (out_rdata_o),
      .out_addr_o          (out_addr_o),
      .out_err_o           (out_err_o),
      .out_is_compressed_o (out_is_compressed_o),
      .instr_new_o         (instr_new_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: queue of pending halfwords in program order
   typedef struct {
      logic [15:0] h;
      logic        e;
      logic        hi;
   } half_t;

   half_t       hq[$];
   logic [31:0] m_pc;
   bit          m_skip;
   bit          m_pres;
   bit          e_valid, e_cmp, e_err;
   logic [31:0] e_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int m_words();
      if (hq.size() == 0) return 0;
      return (hq.size() + (hq[0].hi ? 1 : 0)) / 2;
   endfunction

   task automatic m_reset();
      hq.delete();
      m_pc = '0; m_skip = 0; m_pres = 0;
   endtask

   task automatic m_eval();
      half_t a, b;
      e_valid = 0; e_cmp = 0; e_err = 0; e_rdata = '0;
      if (hq.size() > 0) begin
         a = hq[0];
         if (a.h[1:0] != 2'b11) begin
            e_valid = 1; e_cmp = 1; e_rdata = {16'h0, a.h}; e_err = a.e;
         end else if (hq.size() >= 2) begin
            b = hq[1];
            e_valid = 1; e_rdata = {b.h, a.h}; e_err = a.e | b.e;
         end else if (a.e) begin
            e_valid = 1; e_rdata = {16'h0, a.h}; e_err = 1;
         end
      end
   endtask

   task automatic check_model();
      m_eval();
      chk("ready", in_ready_o, (m_words() < DEPTH));
      chk("valid", out_valid_o, e_valid);
      chk("new", instr_new_o, e_valid & ~m_pres);
      chk("addr", out_addr_o, m_pc);
      chk("cmp", out_is_compressed_o, e_valid & e_cmp);
      if (e_valid) begin
         chk("rdata", out_rdata_o, e_rdata);
         chk("err", out_err_o, e_err);
      end
   endtask

   // One clock: apply inputs, advance model, check at the following negedge
   task automatic drive(input bit clr, input logic [31:0] caddr, input bit iv,
                        input logic [31:0] d, input bit e, input bit ordy);
      bit do_push, do_pop;
      clear_i = clr; clear_addr_i = caddr; in_valid_i = iv;
      in_rdata_i = d; in_err_i = e; out_ready_i = ordy;
      m_eval();
      do_push = iv && (m_words() < DEPTH);
      do_pop  = e_valid && ordy;
      if (clr) begin
         hq.delete();
         m_skip = caddr[1];
         m_pc   = {caddr[31:1], 1'b0};
         m_pres = 0;
      end else begin
         if (do_pop) begin
            if (e_cmp) begin
               void'(hq.pop_front()); m_pc += 2;
            end else if (hq.size() >= 2) begin
               void'(hq.pop_front()); void'(hq.pop_front()); m_pc += 4;
            end else begin
               void'(hq.pop_front()); m_pc += 4; m_skip = 1;
            end
            m_pres = 0;
         end else if (e_valid) begin
            m_pres = 1;
         end
         if (do_push) begin
            if (!m_skip) hq.push_back('{h: d[15:0], e: e, hi: 1'b0});
            hq.push_back('{h: d[31:16], e: e, hi: 1'b1});
            m_skip = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   function automatic logic [15:0] rand_half();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(1) == 1) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11) h[0] = 1'b0;
      return h;
   endfunction

   initial begin
      logic [31:0] held;
      rst_ni = 0; clear_i = 0; clear_addr_i = '0; in_valid_i = 0;
      in_rdata_i = '0; in_err_i = 0; out_ready_i = 0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_ready", in_ready_o, 1);
      chk("rst_addr", out_addr_o, 0);
      chk("rst_new", instr_new_o, 0);
      chk("rst_rdata", out_rdata_o, 0);
      chk("rst_cmp", out_is_compressed_o, 0);
      rst_ni = 1;
      @(negedge clk);
      check_model();

      // aligned 32-bit with stall
      drive(1, 32'h100, 0, 0, 0, 0);
      drive(0, 0, 1, 32'h00B50533, 0, 0);
      chk("al_valid", out_valid_o, 1);
      chk("al_rdata", out_rdata_o, 32'h00B50533);
      chk("al_addr", out_addr_o, 32'h100);
      chk("al_cmp", out_is_compressed_o, 0);
      chk("al_new", instr_new_o, 1);
      held = out_rdata_o;
      drive(0, 0, 0, 0, 0, 0);
      chk("al_new_stall", instr_new_o, 0);
      chk("al_hold", out_rdata_o, 32'h00B50533);
      drive(0, 0, 0, 0, 0, 0);
      chk("al_hold2", out_rdata_o, 32'h00B50533);
      drive(0, 0, 0, 0, 0, 1);
      chk("al_popped", out_valid_o, 0);

      // two compressed in one word
      drive(1, 32'h100, 0, 0, 0, 1);
      drive(0, 0, 1, 32'h45014501, 0, 1);
      chk("c0_rdata", out_rdata_o, 32'h00004501);
      chk("c0_addr", out_addr_o, 32'h100);
      chk("c0_cmp", out_is_compressed_o, 1);
      chk("c0_new", instr_new_o, 1);
      drive(0, 0, 0, 0, 0, 1);
      chk("c1_rdata", out_rdata_o, 32'h00004501);
      chk("c1_addr", out_addr_o, 32'h102);
      chk("c1_new", instr_new_o, 1);
      drive(0, 0, 0, 0, 0, 1);
      chk("c_empty", out_valid_o, 0);

      // misaligned 32-bit
      drive(1, 32'h102, 0, 0, 0, 0);
      drive(0, 0, 1, 32'h05330000, 0, 0);
      chk("mis_wait", out_valid_o, 0);
      drive(0, 0, 1, 32'h000000B5, 0, 0);
      chk("mis_valid", out_valid_o, 1);
      chk("mis_rdata", out_rdata_o, 32'h00B50533);
      chk("mis_addr", out_addr_o, 32'h102);
      drive(0, 0, 0, 0, 0, 1);
      chk("mis_pc", out_addr_o, 32'h106);
      chk("mis_left", out_valid_o, 1);

      // error on first half
      drive(1, 32'h102, 0, 0, 0, 0);
      drive(0, 0, 1, 32'h05330000, 1, 0);
      chk("erh_valid", out_valid_o, 1);
      chk("erh_err", out_err_o, 1);
      chk("erh_rdata", out_rdata_o, 32'h00000533);

      // full, then clear priority
      drive(1, 32'h0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 32'h00000013, 0, 0);
      chk("full_ready", in_ready_o, 0);
      drive(1, 32'h200, 1, 32'h00000013, 0, 1);
      chk("clr_valid", out_valid_o, 0);
      chk("clr_ready", in_ready_o, 1);
      chk("clr_addr", out_addr_o, 32'h200);
      for (int i = 0; i < 3; i++) begin
         chk("clr_cnt_ready", in_ready_o, 1);
         drive(0, 0, 1, 32'h00000013, 0, 0);
      end
      chk("clr_cnt_full", in_ready_o, 0);

      // random traffic
      drive(1, 32'($urandom), 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            rst_ni = 0;
            #1;
            m_reset();
            check_model();
            #1 rst_ni = 1;
         end
         drive($urandom_range(63) == 0, 32'($urandom),
               $urandom_range(9) < 7, {rand_half(), rand_half()},
               $urandom_range(15) == 0, $urandom_range(9) < 6);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
